memory_data_queue: RTL and testbench

- Upstream companion of the Avalon memory bridge.
- Accepts CPU data-side load/store requests and packs each one into a 69-bit command word: [68] write, [67:64] byteenable, [63:32] virtual address, [31:0] write data.
- Buffers commands in a show-ahead FIFO read by the bridge through ram_fifo_q / ram_fifo_empty / ram_fifo_rdreq.
- Tracks the single outstanding data read and returns its result to the CPU from the bridge's registered result bus. Stores are posted; a load blocks the queue until its data returns.

---
 rtl/memory_data_queue.sv | 92 +++++++++
 tb/tb_memory_data_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_data_queue.sv
// CPU data-side request queue: packs load/store requests into 69-bit commands for the Avalon bridge.
// Latency: a push shows on ram_fifo_q one cycle later; load data returns one cycle after the bridge result.
// Backpressure: data_ack drops while the FIFO is full or a load is outstanding.
module memory_data_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_write,
  input  logic [3:0]            data_byteenable,
  input  logic [31:0]           data_address,
  input  logic [31:0]           data_writedata,
  output logic                  data_ack,
  output logic                  data_read_valid,
  output logic [31:0]           data_read_data,
  output logic [68:0]           ram_fifo_q,
  output logic                  ram_fifo_empty,
  input  logic                  ram_fifo_rdreq,
  input  logic                  ram_result_valid,
  input  logic                  ram_result_is_read_instr,
  input  logic [31:0]           ram_result,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  queue_idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [68:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  read_pending;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  data_done;

  assign full           = (count == FULL_CNT);
  assign ram_fifo_empty = (count == '0);
  assign data_ack       = data_req & ~full & ~read_pending;
  assign push           = data_ack;
  assign pop            = ram_fifo_rdreq & ~ram_fifo_empty;
  // Only a data-side result for the outstanding load completes it; fetch results belong elsewhere.
  assign data_done      = read_pending & ram_result_valid & ~ram_result_is_read_instr;

  assign ram_fifo_q = ram_fifo_empty ? 69'd0 : mem[rd_ptr];
  assign fifo_count = count;
  assign queue_idle = ram_fifo_empty & ~read_pending;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {data_write, data_byteenable, data_address,
                      data_write ? data_writedata : 32'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_pending    <= 1'b0;
      data_read_valid <= 1'b0;
      data_read_data  <= 32'd0;
    end else begin
      data_read_valid <= data_done;
      if (data_done) begin
        read_pending   <= 1'b0;
        data_read_data <= ram_result;
      end else if (push && !data_write) begin
        read_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_data_queue.sv
// Bench for memory_data_queue: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_memory_data_queue;

  logic        clk;
  logic        rst;
  logic        data_req;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic        data_ack;
  logic        data_read_valid;
  logic [31:0] data_read_data;
  logic [68:0] ram_fifo_q;
  logic        ram_fifo_empty;
  logic        ram_fifo_rdreq;
  logic        ram_result_valid;
  logic        ram_result_is_read_instr;
  logic [31:0] ram_result;
  logic [3:0]  fifo_count;
  logic        queue_idle;

  memory_data_queue #(.DEPTH_LOG2(3)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .data_req                 (data_req),
    .data_write               (data_write),
    .data_byteenable          (data_byteenable),
    .data_address             (data_address),
    .data_writedata           (data_writedata),
    .data_ack                 (data_ack),
    .data_read_valid          (data_read_valid),
    .data_read_data           (data_read_data),
    .ram_fifo_q               (ram_fifo_q),
    .ram_fifo_empty           (ram_fifo_empty),
    .ram_fifo_rdreq           (ram_fifo_rdreq),
    .ram_result_valid         (ram_result_valid),
    .ram_result_is_read_instr (ram_result_is_read_instr),
    .ram_result               (ram_result),
    .fifo_count               (fifo_count),
    .queue_idle               (queue_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdreq;
    logic        rv;
    logic        ri;
    logic [31:0] res;
    logic        e_ack;
    logic [3:0]  e_cnt;
    logic [68:0] e_q;
    logic        e_rvld;
    logic [31:0] e_rdat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: an unbounded queue capped at 8 by the ack rule, plus load bookkeeping.
  logic [68:0] mq[$];
  logic        m_pend = 1'b0;
  logic        m_rv   = 1'b0;
  logic [31:0] m_rd   = 32'd0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [68:0] cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    return {wr, 4'hF, addr, wr ? wd : 32'd0};
  endfunction

  function automatic vec_t mk(input logic r, input logic req, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rdreq, input logic rv, input logic ri,
                              input logic [31:0] res, input logic e_ack, input logic [3:0] e_cnt,
                              input logic [68:0] e_q, input logic e_rvld, input logic [31:0] e_rdat);
    vec_t v;
    v.rst = r; v.req = req; v.wr = wr; v.be = 4'hF; v.addr = addr; v.wd = wd;
    v.rdreq = rdreq; v.rv = rv; v.ri = ri; v.res = res;
    v.e_ack = e_ack; v.e_cnt = e_cnt; v.e_q = e_q; v.e_rvld = e_rvld; v.e_rdat = e_rdat;
    return v;
  endfunction

  function automatic vec_t io(input logic r, input logic req, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rdreq, input logic rv, input logic ri,
                              input logic [31:0] res);
    return mk(r, req, wr, addr, wd, rdreq, rv, ri, res, 1'b0, 4'd0, 69'd0, 1'b0, 32'd0);
  endfunction

  // One clock: drive at negedge, check ack against the model, advance the model, check registered state.
  task automatic run_cycle(input vec_t v, output logic a);
    logic exp_a;
    logic old_pend;
    @(negedge clk);
    rst = v.rst; data_req = v.req; data_write = v.wr; data_byteenable = v.be;
    data_address = v.addr; data_writedata = v.wd; ram_fifo_rdreq = v.rdreq;
    ram_result_valid = v.rv; ram_result_is_read_instr = v.ri; ram_result = v.res;
    #1;
    a = data_ack;
    exp_a = v.req && (mq.size() < 8) && !m_pend;
    chk("m_ack", {68'd0, a}, {68'd0, exp_a});
    old_pend = m_pend;
    if (v.rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_rv   = 1'b0;
      m_rd   = 32'd0;
    end else begin
      if (v.rdreq && mq.size() > 0) void'(mq.pop_front());
      if (exp_a) begin
        mq.push_back({v.wr, v.be, v.addr, v.wr ? v.wd : 32'd0});
        if (!v.wr) m_pend = 1'b1;
      end
      m_rv = old_pend && v.rv && !v.ri;
      if (m_rv) begin
        m_rd   = v.res;
        m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("m_count", {65'd0, fifo_count}, 69'(mq.size()));
    chk("m_empty", {68'd0, ram_fifo_empty}, {68'd0, mq.size() == 0});
    chk("m_q", ram_fifo_q, mq.size() > 0 ? mq[0] : 69'd0);
    chk("m_idle", {68'd0, queue_idle}, {68'd0, (mq.size() == 0) && !m_pend});
    chk("m_rvld", {68'd0, data_read_valid}, {68'd0, m_rv});
    chk("m_rdat", {37'd0, data_read_data}, {37'd0, m_rd});
  endtask

  vec_t tbl[14];
  vec_t v;
  logic a;
  logic [31:0] base;

  initial begin
    rst = 1'b1; data_req = 1'b0; data_write = 1'b0; data_byteenable = 4'h0;
    data_address = 32'd0; data_writedata = 32'd0; ram_fifo_rdreq = 1'b0;
    ram_result_valid = 1'b0; ram_result_is_read_instr = 1'b0; ram_result = 32'd0;

    //          rst req wr addr          wd            rdq rv ri res           ack cnt q                                       rvld rdat
    tbl[0]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 0, 69'd0,                                  0, 32'h0);
    tbl[1]  = mk(0, 1, 1, 32'h80001000, 32'h11,       0, 0, 0, 32'h0,        1, 1, cmd(1, 32'h80001000, 32'h11),          0, 32'h0);
    tbl[2]  = mk(0, 1, 1, 32'h80001004, 32'h22,       0, 0, 0, 32'h0,        1, 2, cmd(1, 32'h80001000, 32'h11),          0, 32'h0);
    tbl[3]  = mk(0, 1, 1, 32'h80001008, 32'h33,       0, 0, 0, 32'h0,        1, 3, cmd(1, 32'h80001000, 32'h11),          0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        0, 2, cmd(1, 32'h80001004, 32'h22),          0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        0, 1, cmd(1, 32'h80001008, 32'h33),          0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        0, 0, 69'd0,                                  0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        0, 0, 69'd0,                                  0, 32'h0);
    tbl[8]  = mk(0, 1, 0, 32'hA0000010, 32'hFFFFFFFF, 0, 0, 0, 32'h0,        1, 1, 69'h0_F_A0000010_00000000,              0, 32'h0);
    tbl[9]  = mk(0, 1, 1, 32'hB0000000, 32'h55,       1, 0, 0, 32'h0,        0, 0, 69'd0,                                  0, 32'h0);
    tbl[10] = mk(0, 1, 1, 32'hB0000000, 32'h55,       0, 1, 1, 32'h11111111, 0, 0, 69'd0,                                  0, 32'h0);
    tbl[11] = mk(0, 1, 1, 32'hB0000000, 32'h55,       0, 1, 0, 32'hDEADBEEF, 0, 0, 69'd0,                                  1, 32'hDEADBEEF);
    tbl[12] = mk(0, 1, 1, 32'hB0000000, 32'h55,       0, 0, 0, 32'h0,        1, 1, cmd(1, 32'hB0000000, 32'h55),          0, 32'hDEADBEEF);
    tbl[13] = mk(0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 32'hCAFEF00D, 0, 0, 69'd0,                                  0, 32'hDEADBEEF);

    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i], a);
      chk($sformatf("t%0d_ack", i), {68'd0, a}, {68'd0, tbl[i].e_ack});
      chk($sformatf("t%0d_cnt", i), {65'd0, fifo_count}, {65'd0, tbl[i].e_cnt});
      chk($sformatf("t%0d_q", i), ram_fifo_q, tbl[i].e_q);
      chk($sformatf("t%0d_rvld", i), {68'd0, data_read_valid}, {68'd0, tbl[i].e_rvld});
      chk($sformatf("t%0d_rdat", i), {37'd0, data_read_data}, {37'd0, tbl[i].e_rdat});
    end
    chk("reset_idle_after_table", {68'd0, queue_idle}, 69'd1);

    // Fill to full, hold the ninth store, free one slot, then drain to check wrap order.
    run_cycle(io(1, 0, 0, 0, 0, 0, 0, 0, 0), a);
    base = 32'h90000000;
    for (int i = 0; i < 9; i++) begin
      v = io(0, 1, 1, base + 32'(4 * i), 32'(i + 1), 0, 0, 0, 0);
      run_cycle(v, a);
      chk($sformatf("fill%0d_ack", i), {68'd0, a}, {68'd0, i < 8});
    end
    chk("full_count", {65'd0, fifo_count}, 69'd8);
    run_cycle(io(0, 1, 1, base + 32'd32, 32'd9, 1, 0, 0, 0), a);
    chk("full_pop_ack", {68'd0, a}, 69'd0);
    chk("full_pop_count", {65'd0, fifo_count}, 69'd7);
    run_cycle(io(0, 1, 1, base + 32'd32, 32'd9, 0, 0, 0, 0), a);
    chk("refill_ack", {68'd0, a}, 69'd1);
    chk("refill_count", {65'd0, fifo_count}, 69'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_q", i), ram_fifo_q, cmd(1, base + 32'(4 * (i + 1)), 32'(i + 2)));
      run_cycle(io(0, 0, 0, 0, 0, 1, 0, 0, 0), a);
    end
    chk("drain_empty", {68'd0, ram_fifo_empty}, 69'd1);

    // Simultaneous push and pop at count 4.
    for (int i = 0; i < 4; i++) run_cycle(io(0, 1, 1, 32'hC0000000 + 32'(i), 32'(16 + i), 0, 0, 0, 0), a);
    run_cycle(io(0, 1, 1, 32'hC0000010, 32'h77, 1, 0, 0, 0), a);
    chk("pushpop_ack", {68'd0, a}, 69'd1);
    chk("pushpop_count", {65'd0, fifo_count}, 69'd4);
    chk("pushpop_head", ram_fifo_q, cmd(1, 32'hC0000001, 32'd17));

    // Reset with a load pending and stores queued; the late result must be dropped.
    run_cycle(io(1, 0, 0, 0, 0, 0, 0, 0, 0), a);
    run_cycle(io(0, 1, 1, 32'hD0000000, 32'h1, 0, 0, 0, 0), a);
    run_cycle(io(0, 1, 1, 32'hD0000004, 32'h2, 0, 0, 0, 0), a);
    run_cycle(io(0, 1, 0, 32'hD0000008, 32'h0, 0, 0, 0, 0), a);
    chk("pend_idle", {68'd0, queue_idle}, 69'd0);
    run_cycle(io(1, 0, 0, 0, 0, 0, 0, 0, 0), a);
    chk("rst_count", {65'd0, fifo_count}, 69'd0);
    chk("rst_empty", {68'd0, ram_fifo_empty}, 69'd1);
    chk("rst_idle", {68'd0, queue_idle}, 69'd1);
    run_cycle(io(0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678), a);
    chk("late_rvld", {68'd0, data_read_valid}, 69'd0);
    chk("late_rdat", {37'd0, data_read_data}, 69'd0);

    // Random traffic; the CPU holds each request until it is acked.
    begin
      logic have;
      vec_t cur;
      have = 1'b0;
      cur = io(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 800; n++) begin
        if (!have && ($urandom % 3 != 0)) begin
          cur.wr   = ($urandom % 4 != 0);
          cur.be   = 4'($urandom);
          cur.addr = $urandom;
          cur.wd   = $urandom;
          have     = 1'b1;
        end
        cur.req   = have;
        cur.rst   = ($urandom % 80 == 0);
        cur.rdreq = ($urandom % 2 == 0);
        cur.rv    = ($urandom % 4 == 0);
        cur.ri    = ($urandom % 2 == 0);
        cur.res   = $urandom;
        run_cycle(cur, a);
        if (a) have = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
